// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave PHY.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'hFF;
  localparam int FRAME_CNT_W = 16;

  function automatic logic [BYTE_W-1:0] rx_shift_in(input logic [BYTE_W-1:0] cur,
                                                     input logic bit_in,
                                                     input logic msb);
    return msb ? {cur[BYTE_W-2:0], bit_in} : {bit_in, cur[BYTE_W-1:1]};
  endfunction

  function automatic logic [BYTE_W-1:0] tx_shift_out(input logic [BYTE_W-1:0] cur,
                                                      input logic msb);
    return msb ? {cur[BYTE_W-2:0], 1'b0} : {1'b0, cur[BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Host-side byte stream between the SPI slave PHY and its register/FIFO wrapper.
interface spi_slave_if;
  import spi_slave_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_underrun, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_underrun, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchroniser with a configurable reset level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!nrst) ff <= {STAGES{RST_VAL}};
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_phy.sv
// SPI slave PHY: oversampled SCK/MOSI/CS_N, byte deserialiser and MISO serialiser.
// Optional per-frame byte counter enabled by defining SPI_SLAVE_FRAME_CNT_EN.
//
// state     | meaning
// WAIT_IDLE | after reset, wait for a settled CS_N high before accepting frames
// IDLE      | CS_N high, waiting for CS_N fall
// ACTIVE    | frame in progress, sampling/shifting on SCK edges
module spi_slave_phy
  import spi_slave_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       msb_first,
  spi_slave_if.slave host,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       spi_miso_oe
`ifdef SPI_SLAVE_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_bytes,
  output logic                   frame_done
`endif
);

  logic sck_s, mosi_s, cs_s, sck_d, cs_d;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .nrst(nrst), .d(spi_sck),  .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .nrst(nrst), .d(spi_mosi), .q(mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .nrst(nrst), .d(spi_cs_n), .q(cs_s));

  state_t            state;
  logic [2:0]        settle_cnt;
  logic              cpol_l, cpha_l, msb_l;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] rx_shift, rx_data_q, tx_shift, hold;
  logic              rx_pending, rx_valid_q, tx_ready_q, tx_underrun_q, busy_q, oe_q;

  logic sck_rise, sck_fall, sck_lead, sck_trail, sample_edge, shift_edge;
  logic cs_fall, cs_rise, start, in_frame, tx_load, tx_shift_en, rx_sample;

  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign cs_fall     = ~cs_s & cs_d;
  assign cs_rise     = cs_s & ~cs_d;
  assign sck_lead    = cpol_l ? sck_fall : sck_rise;
  assign sck_trail   = cpol_l ? sck_rise : sck_fall;
  assign sample_edge = cpha_l ? sck_trail : sck_lead;
  assign shift_edge  = cpha_l ? sck_lead : sck_trail;

  // CS_N edges win over any SCK edge seen in the same cycle.
  assign start       = (state == IDLE) && cs_fall;
  assign in_frame    = (state == ACTIVE) && !cs_rise;
  assign tx_load     = (start && !cpha) || (in_frame && shift_edge && (bit_cnt == 3'd0));
  assign tx_shift_en = in_frame && shift_edge && (bit_cnt != 3'd0);
  assign rx_sample   = in_frame && sample_edge;

`ifdef SPI_SLAVE_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state         <= WAIT_IDLE;
      settle_cnt    <= 3'(SYNC_STAGES);
      sck_d         <= 1'b0;
      cs_d          <= 1'b1;
      cpol_l        <= 1'b0;
      cpha_l        <= 1'b0;
      msb_l         <= 1'b1;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      rx_data_q     <= '0;
      tx_shift      <= '0;
      hold          <= '0;
      rx_pending    <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
      busy_q        <= 1'b0;
      oe_q          <= 1'b0;
`ifdef SPI_SLAVE_FRAME_CNT_EN
      frame_cnt     <= '0;
      frame_bytes   <= '0;
      frame_done    <= 1'b0;
`endif
    end else begin
      sck_d         <= sck_s;
      cs_d          <= cs_s;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_CNT_EN
      frame_done    <= 1'b0;
`endif

      if (rx_pending) begin
        rx_data_q  <= rx_shift;
        rx_valid_q <= 1'b1;
        rx_pending <= 1'b0;
      end

      // A load that coincides with a host write takes the byte directly,
      // so it is never also parked in the holding register.
      if (tx_load) begin
        if (!tx_ready_q) begin
          tx_shift   <= hold;
          tx_ready_q <= 1'b1;
        end else if (host.tx_valid) begin
          tx_shift <= host.tx_data;
        end else begin
          tx_shift      <= IDLE_BYTE;
          tx_underrun_q <= 1'b1;
        end
      end else begin
        if (tx_shift_en) tx_shift <= tx_shift_out(tx_shift, msb_l);
        if (host.tx_valid && tx_ready_q) begin
          hold       <= host.tx_data;
          tx_ready_q <= 1'b0;
        end
      end

      case (state)
        // The synchroniser resets to CS_N high; counting down until it has
        // flushed avoids reading that reset value as a real idle period.
        WAIT_IDLE: begin
          if (settle_cnt != 3'd0) settle_cnt <= settle_cnt - 3'd1;
          else if (cs_s)          state      <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            cpol_l  <= cpol;
            cpha_l  <= cpha;
            msb_l   <= msb_first;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            oe_q    <= 1'b1;
            state   <= ACTIVE;
`ifdef SPI_SLAVE_FRAME_CNT_EN
            frame_cnt <= '0;
`endif
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            busy_q <= 1'b0;
            oe_q   <= 1'b0;
            state  <= IDLE;
`ifdef SPI_SLAVE_FRAME_CNT_EN
            frame_bytes <= frame_cnt;
            frame_done  <= 1'b1;
`endif
          end else if (rx_sample) begin
            rx_shift <= rx_shift_in(rx_shift, mosi_s, msb_l);
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_pending <= 1'b1;
`ifdef SPI_SLAVE_FRAME_CNT_EN
              if (frame_cnt != {FRAME_CNT_W{1'b1}}) frame_cnt <= frame_cnt + 1'b1;
`endif
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  assign spi_miso         = msb_l ? tx_shift[BYTE_W-1] : tx_shift[0];
  assign spi_miso_oe      = oe_q;
  assign host.tx_ready    = tx_ready_q;
  assign host.tx_underrun = tx_underrun_q;
  assign host.rx_data     = rx_data_q;
  assign host.rx_valid    = rx_valid_q;
  assign host.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_phy.sv
// Scoreboard bench for spi_slave_phy: an SPI master model drives frames,
// expected RX bytes are queued and checked by a monitor on rx_valid.
module tb_spi_slave_phy;
  import spi_slave_pkg::*;

  localparam int H = 6;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, msb_first = 1'b1;
  logic sck = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic miso, miso_oe;

  spi_slave_if bus();

`ifdef SPI_SLAVE_FRAME_CNT_EN
  logic [15:0] frame_bytes;
  logic        frame_done;
`endif

  spi_slave_phy dut (
    .clk(clk), .nrst(nrst), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
    .host(bus.slave),
    .spi_sck(sck), .spi_mosi(mosi), .spi_cs_n(cs_n),
    .spi_miso(miso), .spi_miso_oe(miso_oe)
`ifdef SPI_SLAVE_FRAME_CNT_EN
    , .frame_bytes(frame_bytes), .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int underruns = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_q[$];
  logic [15:0] frame_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // RX scoreboard monitor and underrun pulse counter.
  initial begin
    forever begin
      @(negedge clk);
      if (nrst && bus.tx_underrun) underruns++;
      if (bus.rx_valid) begin
        if (rx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected none", bus.rx_data);
        end else begin
          check("rx_data", bus.rx_data, rx_exp.pop_front());
        end
      end
`ifdef SPI_SLAVE_FRAME_CNT_EN
      if (frame_done) begin
        if (frame_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got %0d expected none", frame_bytes);
        end else begin
          check("frame_bytes", frame_bytes, frame_exp.pop_front());
        end
      end
`endif
    end
  end

  // Host TX feeder: offers the next queued byte whenever the holding register is empty.
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.tx_valid) begin
        void'(tx_q.pop_front());
        bus.tx_valid = 1'b0;
      end
      if (nrst && bus.tx_ready && tx_q.size() > 0) begin
        bus.tx_data  = tx_q[0];
        bus.tx_valid = 1'b1;
      end
    end
  end

  task automatic start_frame(input logic p, input logic h, input logic m);
    cpol = p; cpha = h; msb_first = m;
    sck = p;
    clks(2*H);
    cs_n = 1'b0;
    clks(H);
  endtask

  task automatic end_frame();
    clks(H);
    cs_n = 1'b1;
    clks(2*H);
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      logic bt;
      bt = msb_first ? b[7-i] : b[i];
      if (!cpha) begin
        mosi = bt;
        clks(H);
        sck = ~cpol;
        r = msb_first ? {r[6:0], miso} : {miso, r[7:1]};
        clks(H);
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = bt;
        clks(H);
        sck = cpol;
        r = msb_first ? {r[6:0], miso} : {miso, r[7:1]};
        clks(H);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     bus.busy, 0);
    check({tag, "_miso_oe"},  miso_oe, 0);
    check({tag, "_miso"},     miso, 0);
    check({tag, "_rx_data"},  bus.rx_data, 0);
    check({tag, "_rx_valid"}, bus.rx_valid, 0);
    check({tag, "_tx_ready"}, bus.tx_ready, 1);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] rx3[3];
    logic [7:0] tx3[3];
    int u0;
    rx3[0] = 8'h01; rx3[1] = 8'h80; rx3[2] = 8'hFF;
    tx3[0] = 8'h11; tx3[1] = 8'h22; tx3[2] = 8'h33;

    clks(4);
    check_reset_outputs("reset");
    nrst = 1'b1;
    clks(10);

    // Mode 0, MSB first, preloaded TX byte.
    tx_q.push_back(8'h3C);
    clks(4);
    check("preload_tx_ready", bus.tx_ready, 0);
    u0 = underruns;
    start_frame(1'b0, 1'b0, 1'b1);
    check("m0_busy", bus.busy, 1);
    check("m0_miso_oe", miso_oe, 1);
    rx_exp.push_back(8'hA5);
    xfer(8'hA5, 8, r);
    check("m0_miso", r, 8'h3C);
    end_frame();
    check("m0_busy_end", bus.busy, 0);
    check("m0_underruns", underruns - u0, 1);

    // Modes 1..3, LSB first, 3-byte frames with TX refilled on tx_ready.
    for (int m = 1; m < 4; m++) begin
      logic [1:0] mb;
      mb = 2'(m);
      for (int k = 0; k < 3; k++) tx_q.push_back(tx3[k]);
      clks(6);
      u0 = underruns;
      start_frame(mb[1], mb[0], 1'b0);
      for (int k = 0; k < 3; k++) begin
        rx_exp.push_back(rx3[k]);
        xfer(rx3[k], 8, r);
        check($sformatf("mode%0d_miso%0d", m, k), r, tx3[k]);
      end
      end_frame();
      check($sformatf("mode%0d_underruns", m), underruns - u0, mb[0] ? 0 : 1);
    end

    // No TX data: idle byte on MISO and one underrun per byte (mode 3).
    u0 = underruns;
    start_frame(1'b1, 1'b1, 1'b1);
    rx_exp.push_back(8'h3C);
    xfer(8'h3C, 8, r);
    check("idle_miso0", r, 8'hFF);
    rx_exp.push_back(8'hC3);
    xfer(8'hC3, 8, r);
    check("idle_miso1", r, 8'hFF);
    end_frame();
    check("idle_underruns", underruns - u0, 2);

    // Abort after 5 bits, then a clean frame.
    start_frame(1'b0, 1'b0, 1'b1);
    xfer(8'hE7, 5, r);
    end_frame();
    check("abort_busy", bus.busy, 0);
    check("abort_miso_oe", miso_oe, 0);
    start_frame(1'b0, 1'b0, 1'b1);
    rx_exp.push_back(8'h5A);
    xfer(8'h5A, 8, r);
    end_frame();

    // Reset mid-byte with CS_N held low.
    start_frame(1'b0, 1'b0, 1'b1);
    xfer(8'h99, 4, r);
    nrst = 1'b0;
    clks(3);
    check_reset_outputs("midrst");
    nrst = 1'b1;
    clks(10);
    xfer(8'h66, 8, r);
    clks(10);
    check("midrst_no_frame_busy", bus.busy, 0);
    check("midrst_no_frame_oe", miso_oe, 0);
    end_frame();
    start_frame(1'b0, 1'b0, 1'b1);
    rx_exp.push_back(8'hC3);
    xfer(8'hC3, 8, r);
    end_frame();

`ifdef SPI_SLAVE_FRAME_CNT_EN
    start_frame(1'b0, 1'b0, 1'b1);
    frame_exp.push_back(16'd4);
    for (int k = 0; k < 4; k++) begin
      rx_exp.push_back(8'h10 + 8'(k));
      xfer(8'h10 + 8'(k), 8, r);
    end
    end_frame();
    start_frame(1'b0, 1'b1, 1'b1);
    frame_exp.push_back(16'd2);
    rx_exp.push_back(8'h21);
    xfer(8'h21, 8, r);
    rx_exp.push_back(8'h42);
    xfer(8'h42, 8, r);
    xfer(8'h84, 4, r);
    end_frame();
    clks(20);
    check("frame_bytes_hold", frame_bytes, 16'd2);
    check("frame_queue_drained", frame_exp.size(), 0);
`endif

    clks(20);
    check("rx_queue_drained", rx_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
